// File: rtl/adder_result_buffer_if.sv
// Handshake bundle between the prefix adder, its result buffer and the consumer.
interface adder_result_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  in_cin;
    logic [DATA_WIDTH:0]   in_sum_ext;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_sum;
    logic                  out_carry;
    logic                  out_overflow;
    logic                  out_zero;
    logic                  out_negative;
    logic [CNT_W-1:0]      count;

    // Buffer side
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sum_ext, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_overflow,
               out_zero, out_negative, count
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sum_ext, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_overflow,
               out_zero, out_negative, count
    );
endinterface

// File: rtl/adder_result_buffer.sv
// Registered result FIFO behind the parallel-prefix adder; flags computed at push.
module adder_result_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_result_buffer_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned MSB   = DATA_WIDTH - 1;

    typedef struct packed {
        logic                  carry;
        logic                  overflow;
        logic                  zero;
        logic                  negative;
        logic [DATA_WIDTH-1:0] sum;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;
    entry_t           new_entry_c;
    entry_t           head_c;

    // Occupancy-only handshake status; no path from out_ready to in_ready
    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign push_c  = bus.in_valid && !full_c;
    assign pop_c   = bus.out_ready && !empty_c;

    // Derive status flags from the incoming adder transaction
    always_comb begin
        new_entry_c          = '0;
        new_entry_c.sum      = bus.in_sum_ext[MSB:0];
        new_entry_c.carry    = bus.in_sum_ext[DATA_WIDTH];
        new_entry_c.overflow = (bus.in_a[MSB] == bus.in_b[MSB]) &&
                               (bus.in_sum_ext[MSB] != bus.in_a[MSB]);
        new_entry_c.zero     = ~|bus.in_sum_ext[MSB:0];
        new_entry_c.negative = bus.in_sum_ext[MSB];
    end

    // Storage; reset clears every slot so the outputs read zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push_c) begin
            mem[wr_ptr] <= new_entry_c;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy counter; held on simultaneous push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_c = mem[rd_ptr];

    assign bus.in_ready     = !full_c;
    assign bus.out_valid    = !empty_c;
    assign bus.out_sum      = head_c.sum;
    assign bus.out_carry    = head_c.carry;
    assign bus.out_overflow = head_c.overflow;
    assign bus.out_zero     = head_c.zero;
    assign bus.out_negative = head_c.negative;
    assign bus.count        = count;
endmodule
